// File: rtl/serial_parity_checker_if.sv
// Bus between a serial bit source and serial_parity_checker: the line with its
// bit strobe, plus the received word, its status flags and the error count.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              x;
    logic              bit_en;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
    logic [7:0]        err_cnt;

    modport master (
        output x, bit_en,
        input  data, data_valid, parity_err, frame_err, busy, err_cnt
    );

    modport slave (
        input  x, bit_en,
        output data, data_valid, parity_err, frame_err, busy, err_cnt
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Reports the word with parity/framing flags and keeps a saturating error count.
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    serial_parity_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < 2 || DATA_W > 16) begin : g_bad_width
        $error("serial_parity_checker: DATA_W must be within 2..16");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic              acc;
    logic              perr;
    logic              dv_q;
    logic              pe_q;
    logic              fe_q;
    logic              busy_q;
    logic [7:0]        err_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            data_q <= '0;
            acc    <= 1'b0;
            perr   <= 1'b0;
            dv_q   <= 1'b0;
            pe_q   <= 1'b0;
            fe_q   <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= '0;
        end else begin
            // Result pulses last one clock no matter how sparse the strobes are.
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= 1'b0;
            if (bus.bit_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.x) begin
                            state  <= DATA;
                            busy_q <= 1'b1;
                            cnt    <= '0;
                            shreg  <= '0;
                            acc    <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg <= {bus.x, shreg[DATA_W-1:1]};
                        acc   <= acc ^ bus.x;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PAR;
                        end
                    end
                    PAR: begin
                        perr  <= acc ^ bus.x ^ ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (bus.x) begin
                            data_q <= shreg;
                            dv_q   <= 1'b1;
                            pe_q   <= perr;
                            if (perr && err_q != 8'hFF) begin
                                err_q <= err_q + 8'd1;
                            end
                        end else begin
                            // A low stop bit is only an error, never a new start.
                            fe_q <= 1'b1;
                            if (err_q != 8'hFF) begin
                                err_q <= err_q + 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = busy_q;
    assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even-parity instance for the
// frame scenarios and an odd-parity instance for error-count saturation.
module tb_serial_parity_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_parity_checker_if #(.DATA_W(8)) if0 ();
    serial_parity_checker_if #(.DATA_W(8)) if1 ();

    serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int dv0_cyc  = 0;
    int fe0_cyc  = 0;
    int both_hi  = 0;
    int unstable = 0;
    logic last_pe0 = 1'b0;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (if0.data_valid) begin
            dv0_cyc  = dv0_cyc + 1;
            last_pe0 = if0.parity_err;
        end
        if (if0.frame_err) fe0_cyc = fe0_cyc + 1;
        if (if0.data_valid && if0.frame_err) both_hi = both_hi + 1;
        if (if1.data_valid && if1.frame_err) both_hi = both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit followed by gap-1 idle cycles; the even-parity
    // instance's held outputs must not move during the idle cycles.
    task automatic strobe(input int sel, input logic b, input int gap);
        logic [17:0] snap;
        if (sel == 0) begin
            if0.x = b; if0.bit_en = 1'b1;
        end else begin
            if1.x = b; if1.bit_en = 1'b1;
        end
        tick();
        if0.bit_en = 1'b0;
        if1.bit_en = 1'b0;
        snap = {if0.busy, if0.data, if0.err_cnt, if0.frame_err};
        for (int g = 1; g < gap; g++) begin
            tick();
            if ({if0.busy, if0.data, if0.err_cnt, if0.frame_err} !== snap) unstable++;
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic p,
                        input logic s, input int gap);
        strobe(sel, 1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(sel, d[i], gap);
        strobe(sel, p, gap);
        strobe(sel, s, gap);
    endtask

    initial begin
        int dvb;
        int feb;
        logic [7:0] a5;
        if0.x = 1'b1; if0.bit_en = 1'b0;
        if1.x = 1'b1; if1.bit_en = 1'b0;
        a5 = 8'hA5;

        // Reset state
        repeat (3) tick();
        check("rst_data", if0.data, 32'h00);
        check("rst_dv", if0.data_valid, 0);
        check("rst_pe", if0.parity_err, 0);
        check("rst_fe", if0.frame_err, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_err", if0.err_cnt, 0);
        rst = 1'b0;
        tick();

        // Good frame 0xA5, even parity bit 0
        strobe(0, 1'b0, 1);
        check("good_busy_start", if0.busy, 1);
        for (int i = 0; i < 8; i++) strobe(0, a5[i], 1);
        strobe(0, 1'b0, 1);
        check("good_busy_par", if0.busy, 1);
        strobe(0, 1'b1, 1);
        check("good_dv", if0.data_valid, 1);
        check("good_data", if0.data, 32'hA5);
        check("good_pe", if0.parity_err, 0);
        check("good_fe", if0.frame_err, 0);
        check("good_err", if0.err_cnt, 0);
        check("good_busy_end", if0.busy, 0);
        tick();
        check("good_dv_width", if0.data_valid, 0);

        // Parity error: same frame, parity bit 1
        send(0, 8'hA5, 1'b1, 1'b1, 1);
        check("perr_dv", if0.data_valid, 1);
        check("perr_data", if0.data, 32'hA5);
        check("perr_pe", if0.parity_err, 1);
        check("perr_err", if0.err_cnt, 1);
        tick();
        check("perr_pe_clear", if0.parity_err, 0);

        // Framing error, then 0x3C back-to-back with no idle bit
        feb = fe0_cyc;
        dvb = dv0_cyc;
        send(0, 8'h07, 1'b1, 1'b0, 1);
        check("ferr_fe", if0.frame_err, 1);
        check("ferr_dv", if0.data_valid, 0);
        check("ferr_data", if0.data, 32'hA5);
        check("ferr_err", if0.err_cnt, 2);
        send(0, 8'h3C, 1'b0, 1'b1, 1);
        check("b2b_dv", if0.data_valid, 1);
        check("b2b_data", if0.data, 32'h3C);
        check("b2b_pe", if0.parity_err, 0);
        check("b2b_err", if0.err_cnt, 2);
        tick();
        check("ferr_fe_cycles", fe0_cyc - feb, 1);
        check("b2b_dv_cycles", dv0_cyc - dvb, 1);

        // Gapped strobe: bit_en every 3rd cycle
        dvb = dv0_cyc;
        unstable = 0;
        send(0, 8'hA5, 1'b0, 1'b1, 3);
        tick();
        check("gap_dv_cycles", dv0_cyc - dvb, 1);
        check("gap_pe", last_pe0, 0);
        check("gap_data", if0.data, 32'hA5);
        check("gap_err", if0.err_cnt, 2);
        check("gap_stable", unstable, 0);

        // Reset after 4 data bits, then a full 0x5A frame
        dvb = dv0_cyc;
        feb = fe0_cyc;
        strobe(0, 1'b0, 1);
        for (int i = 0; i < 4; i++) strobe(0, 1'b1, 1);
        rst = 1'b1;
        if0.x = 1'b1; if0.bit_en = 1'b1;
        tick();
        rst = 1'b0;
        if0.bit_en = 1'b0;
        check("mrst_busy", if0.busy, 0);
        check("mrst_data", if0.data, 32'h00);
        repeat (12) tick();
        check("mrst_no_dv", dv0_cyc - dvb, 0);
        check("mrst_no_fe", fe0_cyc - feb, 0);
        send(0, 8'h5A, 1'b0, 1'b1, 1);
        check("mrst_dv", if0.data_valid, 1);
        check("mrst_data_5a", if0.data, 32'h5A);
        check("mrst_pe", if0.parity_err, 0);
        check("mrst_err", if0.err_cnt, 0);

        // Odd parity: 0x00 with parity 0 is wrong; count saturates at 255
        for (int k = 0; k < 300; k++) begin
            send(1, 8'h00, 1'b0, 1'b1, 1);
            if (k == 0) begin
                check("odd_pe_first", if1.parity_err, 1);
                check("odd_err_first", if1.err_cnt, 1);
            end
            if (k == 254) check("sat_err_255", if1.err_cnt, 255);
        end
        check("sat_err_300", if1.err_cnt, 255);
        send(1, 8'h01, 1'b0, 1'b1, 1);
        check("odd_good_dv", if1.data_valid, 1);
        check("odd_good_data", if1.data, 32'h01);
        check("odd_good_pe", if1.parity_err, 0);
        check("odd_good_err", if1.err_cnt, 255);
        tick();

        check("dv_fe_exclusive", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
